// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction-memory interface.
// Assembles a little-endian byte stream into 32-bit words, writes them to
// consecutive word addresses from BASE_ADDR, and holds the core in reset
// until the image is complete.
// Optional: IMEM_LOADER_CHECKSUM_EN appends a trailing checksum word that
// must equal the modulo-2^32 sum of the data words before the core is released.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_word_count,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  // One bit wider than the word count so the capacity compare is exact.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_wcount;
  logic [15:0] r_idx;
  logic [1:0]  r_bcnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  logic [31:0] r_chk;
  logic [31:0] w_chk_word;
`endif

  logic        w_start_ok;
  logic        w_xfer;
  logic        w_last_byte;
  logic        w_too_big;
  logic [15:0] w_idx_inc;

  // start is only honoured when no load is running
  assign w_start_ok  = i_start &&
                       (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_xfer      = i_byte_valid && o_byte_ready;
  assign w_last_byte = (r_bcnt == 2'd3);
  assign w_too_big   = ({1'b0, i_word_count} > DEPTH_L);
  assign w_idx_inc   = r_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  // full checksum word as it stands on the 4th checksum byte
  assign w_chk_word  = {i_byte_data, r_chk[23:0]};
`endif

  // state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state logic and state-decoded outputs
  always_comb begin
    w_state_nxt  = r_state;
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    o_core_reset = 1'b1;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        o_done       = (r_state == S_DONE);
        o_error      = (r_state == S_ERROR);
        o_core_reset = (r_state != S_DONE);
        if (w_start_ok) begin
          if (i_word_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_nxt = S_CHECK;
`else
            w_state_nxt = S_DONE;
`endif
          end else if (w_too_big) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_xfer && w_last_byte) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
        if (w_idx_inc == r_wcount) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_xfer && w_last_byte)
          w_state_nxt = (w_chk_word == r_sum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath: word assembly, address/index tracking, checksum accumulation
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wcount <= '0;
      r_idx    <= '0;
      r_bcnt   <= '0;
      r_addr   <= BASE_ADDR;
      r_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum    <= '0;
      r_chk    <= '0;
`endif
    end else begin
      if (w_start_ok) begin
        r_wcount <= i_word_count;
        r_idx    <= '0;
        r_bcnt   <= '0;
        r_addr   <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum    <= '0;
`endif
      end
      // byte counter wraps to 0 after the 4th byte, so each word starts clean
      if (w_xfer) begin
        r_bcnt <= r_bcnt + 2'd1;
        if (r_state == S_COLLECT) r_wdata[{r_bcnt, 3'b000} +: 8] <= i_byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else                      r_chk[{r_bcnt, 3'b000} +: 8]   <= i_byte_data;
`endif
      end
      if (r_state == S_WRITE) begin
        r_idx  <= w_idx_inc;
        r_addr <= r_addr + 32'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum  <= r_sum + r_wdata;
`endif
      end
    end
  end

  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;

endmodule
